// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared constants for the memory-port arbiter.
//   ARB_CPU_SLICE     : default minimum number of CPU accesses performed between
//                       two external grants while the CPU keeps the port busy.
//   ARB_EXT_MAX_BURST : default maximum number of external accesses per grant.
package mem_arbiter_pkg;

    localparam int ARB_CPU_SLICE     = 4;
    localparam int ARB_EXT_MAX_BURST = 16;

endpackage

// File: rtl/mem_port_mux.sv
// mem_port_mux
// Purely combinational selector that places either the CPU request or the
// external request onto the single memory port.
// Ports:
//   i_selExt                         : 1 selects the external side, 0 the CPU side
//   i_kill                           : forces both memory strobes low
//   i_cpuAddr/Rd/Wr/Byt/Wdata        : CPU-side request
//   i_extAddr/Rd/Wr/Byt/Wdata        : external-side request (strobes pre-qualified)
//   o_memAddr/Rd/Wr/Byt/Wdata        : memory macro port
module mem_port_mux (
    input  logic        i_selExt,
    input  logic        i_kill,
    input  logic [15:0] i_cpuAddr,
    input  logic        i_cpuRd,
    input  logic        i_cpuWr,
    input  logic        i_cpuByt,
    input  logic [15:0] i_cpuWdata,
    input  logic [15:0] i_extAddr,
    input  logic        i_extRd,
    input  logic        i_extWr,
    input  logic        i_extByt,
    input  logic [15:0] i_extWdata,
    output logic [15:0] o_memAddr,
    output logic        o_memRd,
    output logic        o_memWr,
    output logic        o_memByt,
    output logic [15:0] o_memWdata
);

    // Address, data and byte flag are free to follow the select; only the
    // strobes are gated, since they alone cause a memory side effect.
    assign o_memAddr  = i_selExt ? i_extAddr  : i_cpuAddr;
    assign o_memWdata = i_selExt ? i_extWdata : i_cpuWdata;
    assign o_memByt   = i_selExt ? i_extByt   : i_cpuByt;
    assign o_memRd    = ~i_kill & (i_selExt ? i_extRd : i_cpuRd);
    assign o_memWr    = ~i_kill & (i_selExt ? i_extWr : i_cpuWr);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the CPU's single synchronous memory port between the CPU datapath
// and an external master (program loader / debug port). The external master
// is granted the port in time slices; while it owns the port the CPU is stalled.
// Ports:
//   clk, rst                            : clock, synchronous active-high reset
//   cpu_addr/rd/wr/byt/wdata            : CPU request
//   cpu_rdata, cpu_stall                : CPU read data and stall
//   ext_req/addr/wr/byt/wdata           : external request (held until granted)
//   ext_gnt, ext_rdata, ext_rvalid      : external grant, read data, read valid
//   mem_addr/rd/wr/byt/wdata, mem_rdata : memory macro port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPU_SLICE     = ARB_CPU_SLICE,
    parameter int EXT_MAX_BURST = ARB_EXT_MAX_BURST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_byt,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic [15:0] ext_addr,
    input  logic        ext_wr,
    input  logic        ext_byt,
    input  logic [15:0] ext_wdata,
    output logic        ext_gnt,
    output logic [15:0] ext_rdata,
    output logic        ext_rvalid,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_byt,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_EXT = 1'b1
    } arbState_t;

    localparam int WAIT_W  = $clog2(CPU_SLICE + 1);
    localparam int BURST_W = $clog2(EXT_MAX_BURST + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CPU_SLICE - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(CPU_SLICE);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(EXT_MAX_BURST - 1);

    arbState_t          r_state;
    logic [WAIT_W-1:0]  r_waitCnt;
    logic [BURST_W-1:0] r_burstCnt;
    logic               r_extRvalid;

    logic w_cpuBusy;
    logic w_selExt;
    logic w_extRd;
    logic w_extWr;

    assign w_cpuBusy = cpu_rd | cpu_wr;
    assign w_selExt  = (r_state == S_EXT);

    // External strobes are only meaningful while the request is held.
    assign w_extRd = ext_req & ~ext_wr;
    assign w_extWr = ext_req & ext_wr;

    // Handshake outputs are forced inactive during reset so neither master
    // believes an access happened while the memory strobes are killed.
    assign ext_gnt    = w_selExt & ext_req & ~rst;
    assign cpu_stall  = w_selExt & w_cpuBusy & ~rst;
    assign ext_rvalid = r_extRvalid;

    // Memory read data is returned unregistered to both masters; only the
    // one that issued the read last cycle will consume it.
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

    // In S_EXT the CPU side is not selected at all, so the ignored CPU
    // request never reaches the memory; the kill only has to cover reset.
    mem_port_mux u_mux (
        .i_selExt   (w_selExt),
        .i_kill     (rst),
        .i_cpuAddr  (cpu_addr),
        .i_cpuRd    (cpu_rd),
        .i_cpuWr    (cpu_wr),
        .i_cpuByt   (cpu_byt),
        .i_cpuWdata (cpu_wdata),
        .i_extAddr  (ext_addr),
        .i_extRd    (w_extRd),
        .i_extWr    (w_extWr),
        .i_extByt   (ext_byt),
        .i_extWdata (ext_wdata),
        .o_memAddr  (mem_addr),
        .o_memRd    (mem_rd),
        .o_memWr    (mem_wr),
        .o_memByt   (mem_byt),
        .o_memWdata (mem_wdata)
    );

    // Ownership FSM. In S_CPU the wait counter measures how long the
    // external master has been held off by a busy CPU; once the CPU has had
    // its slice (or is idle) ownership moves over, with the CPU's access in
    // the deciding cycle still performed. In S_EXT the burst counter limits
    // how long the CPU can be stalled; the grant ends early if the external
    // master drops its request. The read-valid flag lags a granted read by
    // one cycle, matching the memory's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_CPU;
            r_waitCnt   <= '0;
            r_burstCnt  <= '0;
            r_extRvalid <= 1'b0;
        end else begin
            r_extRvalid <= w_selExt & ext_req & ~ext_wr;
            case (r_state)
                S_CPU: begin
                    if (ext_req & (~w_cpuBusy | (r_waitCnt >= WAIT_LAST))) begin
                        r_state   <= S_EXT;
                        r_waitCnt <= '0;
                    end else if (ext_req & w_cpuBusy & (r_waitCnt != WAIT_MAX)) begin
                        r_waitCnt <= r_waitCnt + WAIT_W'(1);
                    end
                end
                S_EXT: begin
                    if (~ext_req | (r_burstCnt >= BURST_LAST)) begin
                        r_state    <= S_CPU;
                        r_burstCnt <= '0;
                    end else begin
                        r_burstCnt <= r_burstCnt + BURST_W'(1);
                    end
                end
                default: begin
                    r_state <= S_CPU;
                end
            endcase
        end
    end

endmodule
